send_ram: RTL and testbench

- Transmit-side ping-pong sample buffer, the counterpart of the receive capture buffer.
- The DSP writes 32-bit {Q,I} words sequentially into one half of an internal dual-port RAM. The block plays the other half out at the 200 kHz sample rate, derived from clk_50m.
- When a half has been fully played out, the block pulses write_quest so the DSP refills that half.
- Sits between the McBSP/DSP write path and the 200 kHz modulator input.

---
 rtl/send_ram_if.sv | 27 ++
 rtl/send_ram.sv | 167 ++++++++++++++++
 tb/tb_send_ram.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/send_ram_if.sv
// send_ram port bundle: slot control, DSP write path, and the 200 kHz sample outputs.
// The bench or the DSP side takes the master modport. send_ram takes the slave modport.
interface send_ram_if;
  logic        tx_enable;
  logic        init_tx_slot;
  logic        dsp_wr_en;
  logic [31:0] dsp_wr_data;
  logic        write_quest;
  logic [15:0] data_200k_i_out;
  logic [15:0] data_200k_q_out;
  logic        sample_valid;
  logic        underrun_err;
  logic        overflow_err;
  logic [63:0] tx_debug;

  modport master (
    output tx_enable, init_tx_slot, dsp_wr_en, dsp_wr_data,
    input  write_quest, data_200k_i_out, data_200k_q_out, sample_valid,
           underrun_err, overflow_err, tx_debug
  );

  modport slave (
    input  tx_enable, init_tx_slot, dsp_wr_en, dsp_wr_data,
    output write_quest, data_200k_i_out, data_200k_q_out, sample_valid,
           underrun_err, overflow_err, tx_debug
  );
endinterface

// File: rtl/send_ram.sv
// Ping-pong TX buffer: the DSP fills one half while the other half plays out, one sample every DIV clocks.
// A sample appears 2 cycles after its strobe. There is no backpressure: a write into a full half is dropped and flagged.
module send_ram #(
  parameter int HALF_DEPTH = 1024,
  parameter int ADDR_W     = 11,
  parameter int DIV        = 250
) (
  input  logic      clk_50m,
  input  logic      cfg_rst_n,
  send_ram_if.slave bus
);
  localparam int PTR_W = (HALF_DEPTH > 1) ? $clog2(HALF_DEPTH) : 1;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 2 * HALF_DEPTH;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(HALF_DEPTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRIME = 2'd1, S_RUN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [1:0]         valid_q, valid_d;
  logic               w_half_q, w_half_d, r_half_q, r_half_d;
  logic [PTR_W-1:0]   w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               underrun_q, underrun_d, overflow_q, overflow_d;
  logic               write_quest_q, write_quest_d;
  logic               rd_pend_q, rd_pend_d, rd_hit_q, rd_hit_d;
  logic               sample_valid_q, sample_valid_d;
  logic [15:0]        i_out_q, i_out_d, q_out_q, q_out_d;

  logic               strobe, wr_ok, rd_ok, wr_last, rd_last, ram_we;
  logic [ADDR_W-1:0]  wr_addr, rd_addr;
  logic [31:0]        mem [DEPTH];
  logic [31:0]        ram_rd_q;

  always_comb begin
    strobe  = (state_q == S_RUN) && (div_cnt_q == DIV_LAST);
    wr_ok   = bus.dsp_wr_en && !valid_q[w_half_q];
    rd_ok   = strobe && valid_q[r_half_q];
    wr_last = wr_ok && (w_ptr_q == PTR_LAST);
    rd_last = rd_ok && (r_ptr_q == PTR_LAST);
    ram_we  = wr_ok && !bus.init_tx_slot;
    wr_addr = (w_half_q ? ADDR_W'(HALF_DEPTH) : ADDR_W'(0)) + ADDR_W'(w_ptr_q);
    rd_addr = (r_half_q ? ADDR_W'(HALF_DEPTH) : ADDR_W'(0)) + ADDR_W'(r_ptr_q);
  end

  always_ff @(posedge clk_50m) begin
    if (ram_we) mem[wr_addr] <= bus.dsp_wr_data;
    if (rd_ok)  ram_rd_q     <= mem[rd_addr];
  end

  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    w_half_d       = w_half_q;
    w_ptr_d        = w_ptr_q;
    r_half_d       = r_half_q;
    r_ptr_d        = r_ptr_q;
    div_cnt_d      = '0;
    underrun_d     = underrun_q | (strobe && !valid_q[r_half_q]);
    overflow_d     = overflow_q | (bus.dsp_wr_en && valid_q[w_half_q]);
    write_quest_d  = rd_last;
    rd_pend_d      = strobe;
    rd_hit_d       = rd_ok;
    sample_valid_d = rd_pend_q;
    i_out_d        = i_out_q;
    q_out_d        = q_out_q;

    case (state_q)
      S_IDLE:  if (bus.tx_enable) state_d = S_PRIME;
      S_PRIME: if (!bus.tx_enable) state_d = S_IDLE;
               else if (valid_q[r_half_q]) state_d = S_RUN;
      S_RUN:   if (!bus.tx_enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_RUN) div_cnt_d = strobe ? '0 : div_cnt_q + DIV_W'(1);

    if (wr_ok) begin
      w_ptr_d = wr_last ? '0 : w_ptr_q + PTR_W'(1);
      if (wr_last) begin
        w_half_d          = ~w_half_q;
        valid_d[w_half_q] = 1'b1;
      end
    end

    // The reader only clears a half the writer is not allowed to touch, so both updates can apply together.
    if (rd_ok) begin
      r_ptr_d = rd_last ? '0 : r_ptr_q + PTR_W'(1);
      if (rd_last) begin
        r_half_d          = ~r_half_q;
        valid_d[r_half_q] = 1'b0;
      end
    end

    if (rd_pend_q) begin
      i_out_d = rd_hit_q ? ram_rd_q[15:0]  : 16'h0;
      q_out_d = rd_hit_q ? ram_rd_q[31:16] : 16'h0;
    end else if (state_q != S_RUN) begin
      i_out_d = 16'h0;
      q_out_d = 16'h0;
    end

    if (bus.init_tx_slot) begin
      state_d        = bus.tx_enable ? S_PRIME : S_IDLE;
      valid_d        = 2'b00;
      w_half_d       = 1'b0;
      w_ptr_d        = '0;
      r_half_d       = 1'b0;
      r_ptr_d        = '0;
      div_cnt_d      = '0;
      underrun_d     = 1'b0;
      overflow_d     = 1'b0;
      write_quest_d  = 1'b1;
      rd_pend_d      = 1'b0;
      rd_hit_d       = 1'b0;
      sample_valid_d = 1'b0;
      i_out_d        = 16'h0;
      q_out_d        = 16'h0;
    end
  end

  always_ff @(posedge clk_50m or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      state_q        <= S_IDLE;
      valid_q        <= 2'b00;
      w_half_q       <= 1'b0;
      w_ptr_q        <= '0;
      r_half_q       <= 1'b0;
      r_ptr_q        <= '0;
      div_cnt_q      <= '0;
      underrun_q     <= 1'b0;
      overflow_q     <= 1'b0;
      write_quest_q  <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_hit_q       <= 1'b0;
      sample_valid_q <= 1'b0;
      i_out_q        <= 16'h0;
      q_out_q        <= 16'h0;
    end else begin
      state_q        <= state_d;
      valid_q        <= valid_d;
      w_half_q       <= w_half_d;
      w_ptr_q        <= w_ptr_d;
      r_half_q       <= r_half_d;
      r_ptr_q        <= r_ptr_d;
      div_cnt_q      <= div_cnt_d;
      underrun_q     <= underrun_d;
      overflow_q     <= overflow_d;
      write_quest_q  <= write_quest_d;
      rd_pend_q      <= rd_pend_d;
      rd_hit_q       <= rd_hit_d;
      sample_valid_q <= sample_valid_d;
      i_out_q        <= i_out_d;
      q_out_q        <= q_out_d;
    end
  end

  assign bus.write_quest     = write_quest_q;
  assign bus.data_200k_i_out = i_out_q;
  assign bus.data_200k_q_out = q_out_q;
  assign bus.sample_valid    = sample_valid_q;
  assign bus.underrun_err    = underrun_q;
  assign bus.overflow_err    = overflow_q;
  assign bus.tx_debug        = 64'({state_q, valid_q, w_half_q, w_ptr_q, r_half_q, r_ptr_q,
                                     div_cnt_q, underrun_q, overflow_q});
endmodule

// File: tb/tb_send_ram.sv
// Randomized and directed bench for send_ram. A block-queue reference model predicts every output on every cycle.
module tb_send_ram;
  localparam int HD  = 8;
  localparam int AW  = 4;
  localparam int DIV = 250;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #10 clk = ~clk;

  send_ram_if bus();
  send_ram #(.HALF_DEPTH(HD), .ADDR_W(AW), .DIV(DIV)) dut (
    .clk_50m(clk), .cfg_rst_n(rst_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: completed halves live in m_ready in playout order. m_acc holds the half being filled.
  int          m_state;
  int          m_div;
  logic [31:0] m_ready[$];
  logic [31:0] m_acc[$];
  bit          m_und, m_ovf;
  bit          p1_v, p1_hit;
  logic [31:0] p1_dat;
  bit          e_sv, e_wq;
  logic [15:0] e_i, e_q;

  task automatic model_reset();
    m_state = 0; m_div = 0;
    m_ready.delete(); m_acc.delete();
    m_und = 0; m_ovf = 0;
    p1_v = 0; p1_hit = 0; p1_dat = '0;
    e_sv = 0; e_wq = 0; e_i = '0; e_q = '0;
  endtask

  task automatic model_step();
    int n;
    bit strobe;
    if (!rst_n) begin model_reset(); return; end
    if (bus.init_tx_slot) begin
      model_reset();
      m_state = bus.tx_enable ? 1 : 0;
      e_wq = 1;
      return;
    end
    n      = (m_ready.size() + HD - 1) / HD;
    strobe = (m_state == 2) && (m_div == DIV - 1);
    if (p1_v) begin
      e_sv = 1;
      e_i  = p1_hit ? p1_dat[15:0]  : 16'h0;
      e_q  = p1_hit ? p1_dat[31:16] : 16'h0;
    end else begin
      e_sv = 0;
      if (m_state != 2) begin e_i = 16'h0; e_q = 16'h0; end
    end
    p1_v = strobe; p1_hit = 0; e_wq = 0;
    if (strobe) begin
      if (m_ready.size() > 0) begin
        p1_hit = 1;
        p1_dat = m_ready.pop_front();
        if (m_ready.size() % HD == 0) e_wq = 1;
      end else m_und = 1;
    end
    if (bus.dsp_wr_en) begin
      if (n == 2) m_ovf = 1;
      else begin
        m_acc.push_back(bus.dsp_wr_data);
        if (m_acc.size() == HD) begin
          foreach (m_acc[k]) m_ready.push_back(m_acc[k]);
          m_acc.delete();
        end
      end
    end
    m_div = (m_state == 2) ? (strobe ? 0 : m_div + 1) : 0;
    case (m_state)
      0: if (bus.tx_enable) m_state = 1;
      1: if (!bus.tx_enable) m_state = 0; else if (n > 0) m_state = 2;
      default: if (!bus.tx_enable) m_state = 0;
    endcase
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    cmp("sample_valid", 64'(bus.sample_valid), 64'(e_sv));
    cmp("write_quest",  64'(bus.write_quest),  64'(e_wq));
    cmp("data_i",       64'(bus.data_200k_i_out), 64'(e_i));
    cmp("data_q",       64'(bus.data_200k_q_out), 64'(e_q));
    cmp("underrun_err", 64'(bus.underrun_err), 64'(m_und));
    cmp("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wr(input logic [31:0] d);
    bus.dsp_wr_en = 1'b1; bus.dsp_wr_data = d;
    tick();
    bus.dsp_wr_en = 1'b0;
  endtask

  task automatic init_slot();
    bus.init_tx_slot = 1'b1;
    tick();
    bus.init_tx_slot = 1'b0;
  endtask

  task automatic wait_sv(input int budget, output int n);
    n = 0;
    do begin tick(); n++; end while (!bus.sample_valid && n < budget);
    if (!bus.sample_valid) begin
      vectors++; miscompares++;
      $display("FAIL sample_valid_timeout at %0t: got none within %0d cycles", $time, budget);
    end
  endtask

  int n, seen, credit, off;

  initial begin
    rst_n = 1'b0;
    bus.tx_enable = 1'b0; bus.init_tx_slot = 1'b0; bus.dsp_wr_en = 1'b0; bus.dsp_wr_data = '0;
    model_reset();
    repeat (3) tick();
    cmp("reset_debug", bus.tx_debug, 64'h0);
    rst_n = 1'b1;
    tick();

    // Init with slot active: PRIME, write_quest one cycle later.
    bus.tx_enable = 1'b1;
    init_slot();
    cmp("init_write_quest", 64'(bus.write_quest), 64'd1);
    cmp("init_state_prime", 64'(bus.tx_debug[21:20]), 64'd1);
    tick();
    cmp("write_quest_single", 64'(bus.write_quest), 64'd0);

    // One half of ramp data, played out 250 cycles apart.
    for (int k = 0; k < HD; k++) wr({16'(k + 1), 16'(k)});
    cmp("valid_after_fill", 64'(bus.tx_debug[19:18]), 64'd1);
    wait_sv(400, n);
    cmp("first_latency", 64'(n), 64'd252);
    cmp("first_q", 64'(bus.data_200k_q_out), 64'h1);
    cmp("first_i", 64'(bus.data_200k_i_out), 64'h0);
    for (int s = 2; s <= HD; s++) begin
      wait_sv(400, n);
      cmp("sample_period", 64'(n), 64'd250);
    end
    cmp("last_q", 64'(bus.data_200k_q_out), 64'h8);
    cmp("last_i", 64'(bus.data_200k_i_out), 64'h7);

    // Both halves full, then a 17th word overflows and is never played.
    init_slot();
    for (int k = 0; k < 2 * HD + 1; k++) wr(32'h00A0_0000 + 32'(k));
    cmp("overflow_set", 64'(bus.overflow_err), 64'd1);
    for (int s = 0; s < 2 * HD; s++) wait_sv(600, n);
    cmp("sixteenth_i", 64'(bus.data_200k_i_out), 64'hF);
    wait_sv(400, n);
    cmp("seventeenth_zero", 64'({bus.data_200k_q_out, bus.data_200k_i_out}), 64'h0);
    cmp("underrun_after_16", 64'(bus.underrun_err), 64'd1);

    // Only half 0 filled: the ninth strobe underruns, with the read pointer parked at half 1, index 0.
    init_slot();
    for (int k = 0; k < HD; k++) wr(32'h00C0_0000 + 32'(k));
    for (int s = 0; s < HD; s++) wait_sv(600, n);
    cmp("no_underrun_yet", 64'(bus.underrun_err), 64'd0);
    wait_sv(400, n);
    cmp("ninth_zero", 64'({bus.data_200k_q_out, bus.data_200k_i_out}), 64'h0);
    cmp("ninth_underrun", 64'(bus.underrun_err), 64'd1);
    cmp("r_half_one", 64'(bus.tx_debug[13]), 64'd1);
    cmp("r_ptr_zero", 64'(bus.tx_debug[12:10]), 64'd0);

    // Pause after three samples; playout resumes at word 4 with the divider restarted.
    init_slot();
    for (int k = 0; k < HD; k++) wr(32'h00B0_0000 + 32'(k));
    for (int s = 0; s < 3; s++) wait_sv(600, n);
    bus.tx_enable = 1'b0;
    repeat (100) tick();
    cmp("paused_idle", 64'(bus.tx_debug[21:20]), 64'd0);
    cmp("paused_div_zero", 64'(bus.tx_debug[9:2]), 64'd0);
    bus.tx_enable = 1'b1;
    wait_sv(600, n);
    cmp("resume_latency", 64'(n), 64'd253);
    cmp("resume_word4", 64'({bus.data_200k_q_out, bus.data_200k_i_out}), 64'h00B0_0003);

    // Init while running with both halves valid flushes everything.
    init_slot();
    for (int k = 0; k < 2 * HD; k++) wr(32'h00D0_0000 + 32'(k));
    wait_sv(600, n);
    init_slot();
    cmp("flush_write_quest", 64'(bus.write_quest), 64'd1);
    cmp("flush_valid", 64'(bus.tx_debug[19:18]), 64'd0);
    cmp("flush_flags", 64'(bus.tx_debug[1:0]), 64'd0);
    seen = 0;
    for (int c = 0; c < 600; c++) begin tick(); if (bus.sample_valid) seen++; end
    cmp("flush_no_samples", 64'(seen), 64'd0);

    // Random phase: DSP answers write_quest, with pauses, stray writes and occasional re-init.
    credit = 0; off = 0;
    for (int c = 0; c < 30000; c++) begin
      bus.init_tx_slot = ($urandom_range(0, 7999) == 0);
      if (bus.init_tx_slot) credit = 0;
      if (off > 0) begin
        off--;
        if (off == 0) bus.tx_enable = 1'b1;
      end else if ($urandom_range(0, 2999) == 0) begin
        bus.tx_enable = 1'b0;
        off = $urandom_range(50, 500);
      end
      if (credit > 0 && $urandom_range(0, 9) < 7) begin
        bus.dsp_wr_en = 1'b1; bus.dsp_wr_data = $urandom; credit--;
      end else if ($urandom_range(0, 1999) == 0) begin
        bus.dsp_wr_en = 1'b1; bus.dsp_wr_data = $urandom;
      end else bus.dsp_wr_en = 1'b0;
      tick();
      if (bus.write_quest) credit += ($urandom_range(0, 3) == 0) ? 2 * HD : HD;
    end
    bus.dsp_wr_en = 1'b0; bus.init_tx_slot = 1'b0;

    // Asynchronous reset between clock edges.
    #3 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    cmp("async_reset_debug", bus.tx_debug, 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
